// File: rtl/imem_read_port_pkg.sv
// Shared definitions for the instruction-memory read port: state codes,
// error-response defaults and the address legality rule.
package imem_read_port_pkg;

  localparam logic [1:0] IMEM_IDLE = 2'd0;
  localparam logic [1:0] IMEM_WAIT = 2'd1;
  localparam logic [1:0] IMEM_HOLD = 2'd2;

  localparam logic [31:0] IMEM_NOP_WORD = 32'h0000_0000;

  // Error flag sits directly above the 32-bit instruction word.
  localparam int unsigned IMEM_ERR_BIT = 32;

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } imem_resp_t;

  // Word-aligned and inside the 2^aw-word instruction BRAM.
  function automatic logic imem_addr_legal(input logic [31:0] addr, input int unsigned aw);
    return (addr[1:0] == 2'b00) && ((addr >> (aw + 2)) == 32'd0);
  endfunction

endpackage

// File: rtl/imem_read_port_if.sv
// Fetch-side request/response bundle between the fetch stage (master)
// and the instruction-memory read port (slave).
interface imem_read_port_if;
  logic [31:0] S_ARADDR;
  logic        S_ARVALID;
  logic        S_RREADY;
  logic [31:0] S_RDATA;
  logic        S_RVALID;
  logic        S_RERR;

  modport master (
    output S_ARADDR, S_ARVALID, S_RREADY,
    input  S_RDATA, S_RVALID, S_RERR
  );

  modport slave (
    input  S_ARADDR, S_ARVALID, S_RREADY,
    output S_RDATA, S_RVALID, S_RERR
  );
endinterface

// File: rtl/imem_read_port_latency_counter.sv
// Down-counter tracking the BRAM read latency; flags the cycle in which
// it steps from 1 to 0, i.e. when the BRAM output is valid.
module imem_latency_counter #(
  parameter int unsigned MAX = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic dec,
  output logic zero_next
);
  localparam int unsigned W = $clog2(MAX + 1);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= W'(MAX);
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero_next = dec && (count == W'(1));
endmodule

// File: rtl/imem_read_port.sv
// Instruction-memory read port: issues one fixed-latency BRAM read per fetch
// request, holds the word until consumed, and answers illegal addresses with an error.
module imem_read_port
  import imem_read_port_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 12,
  parameter int unsigned READ_LATENCY = 2,
  parameter logic [31:0] NOP_WORD     = IMEM_NOP_WORD
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  FLUSH,
  imem_read_port_if.slave       fetch,
  output logic                  BRAM_EN,
  output logic [ADDR_WIDTH-1:0] BRAM_ADDR,
  input  logic [31:0]           BRAM_DOUT
);
  logic [1:0] state, state_next;
  imem_resp_t resp, resp_next;
  logic       legal;
  logic       issue;
  logic       zero_next;

  assign legal = imem_addr_legal(fetch.S_ARADDR, ADDR_WIDTH);
  assign issue = rst_n && (state == IMEM_IDLE) && fetch.S_ARVALID && legal;

  assign BRAM_EN   = issue;
  assign BRAM_ADDR = fetch.S_ARADDR[ADDR_WIDTH+1:2];

  imem_latency_counter #(
    .MAX (READ_LATENCY)
  ) u_latency (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (issue),
    .dec       (state == IMEM_WAIT),
    .zero_next (zero_next)
  );

  // A flushed read simply leaves WAIT; its late BRAM data lands before any
  // reissued read expires, so no explicit discard tracking is needed.
  always_comb begin
    state_next = state;
    resp_next  = resp;
    if (FLUSH) begin
      state_next    = IMEM_IDLE;
      resp_next.err = 1'b0;
    end else begin
      case (state)
        IMEM_IDLE: begin
          if (fetch.S_ARVALID) begin
            if (legal) begin
              state_next = IMEM_WAIT;
            end else begin
              state_next = IMEM_HOLD;
              resp_next  = '{err: 1'b1, data: NOP_WORD};
            end
          end
        end
        IMEM_WAIT: begin
          if (zero_next) begin
            state_next = IMEM_HOLD;
            resp_next  = '{err: 1'b0, data: BRAM_DOUT};
          end
        end
        IMEM_HOLD: begin
          if (fetch.S_RREADY) begin
            state_next    = IMEM_IDLE;
            resp_next.err = 1'b0;
          end
        end
        default: state_next = IMEM_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IMEM_IDLE;
      resp  <= '0;
    end else begin
      state <= state_next;
      resp  <= resp_next;
    end
  end

  assign fetch.S_RVALID = (state == IMEM_HOLD);
  assign fetch.S_RDATA  = resp.data;
  assign fetch.S_RERR   = resp[IMEM_ERR_BIT];
endmodule

// File: tb/tb_imem_read_port.sv
// Randomized bench for imem_read_port at read latencies 1, 2 and 4, each lane
// checked cycle by cycle against a transaction-timing reference model.
`timescale 1ns/1ps
module tb_imem_read_port;
  localparam int unsigned AW   = 12;
  localparam int          NONE = 1000;

  typedef struct {
    logic [31:0] addr;
    int          hold;
    int          flush_at;
    int          reset_at;
    int          gap;
  } req_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned tests_run    = 0;
  int unsigned tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // BRAM contents; word 4 is the well-known pattern used by the directed reads.
  function automatic logic [31:0] word_data(input int unsigned w);
    if (w == 4) return 32'hDEAD_BEEF;
    return (w * 32'h9E37_79B1) ^ 32'h5A5A_0000 ^ w;
  endfunction

  function automatic logic addr_ok(input logic [31:0] a);
    return (a % 4 == 0) && (a < (32'd4 << AW));
  endfunction

  function automatic req_t rand_req(input int unsigned lat);
    req_t        r;
    int unsigned p = $urandom_range(0, 9);
    if (p < 7)       r.addr = $urandom_range(0, 4095) * 4;
    else if (p == 7) r.addr = ($urandom_range(0, 4095) * 4) | $urandom_range(1, 3);
    else if (p == 8) r.addr = ($urandom | 32'h0000_4000) & 32'hFFFF_FFFC;
    else             r.addr = 32'h0000_3FFC;
    r.hold     = $urandom_range(0, 3);
    r.flush_at = ($urandom_range(0, 5) == 0) ? $urandom_range(0, lat + 2) : NONE;
    r.reset_at = ($urandom_range(0, 19) == 0) ? $urandom_range(0, lat + 1) : NONE;
    r.gap      = $urandom_range(0, 2);
    return r;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : lane
    localparam int unsigned LAT = (g == 0) ? 1 : ((g == 1) ? 2 : 4);

    imem_read_port_if bus ();
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          bram_en;
    logic [AW-1:0] bram_addr;
    logic [31:0]   bram_dout;
    logic          done = 1'b0;

    imem_read_port #(
      .ADDR_WIDTH   (AW),
      .READ_LATENCY (LAT),
      .NOP_WORD     (32'h0000_0000)
    ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .FLUSH     (flush),
      .fetch     (bus),
      .BRAM_EN   (bram_en),
      .BRAM_ADDR (bram_addr),
      .BRAM_DOUT (bram_dout)
    );

    // BRAM: data valid exactly LAT cycles after the enable, noise otherwise.
    logic [LAT-1:0] pv = '0;
    logic [AW-1:0]  pa [LAT];
    logic [31:0]    noise = '0;
    always @(posedge clk) begin
      for (int i = LAT - 1; i > 0; i--) begin
        pv[i] <= pv[i-1];
        pa[i] <= pa[i-1];
      end
      pv[0] <= bram_en;
      pa[0] <= bram_addr;
      noise <= $urandom;
    end
    assign bram_dout = pv[LAT-1] ? word_data(32'(pa[LAT-1])) : noise;

    // Reference model: a legal request issued in cycle T answers from T+LAT+1.
    int unsigned cyc = 0, due = 0, m_word = 0;
    logic        m_valid = 1'b0, m_err = 1'b0, m_busy = 1'b0;
    logic        m_rzero = 1'b0, m_quiet = 1'b0;
    logic [31:0] m_data = '0;
    always @(posedge clk) begin
      if (!rst_n) begin
        m_valid <= 1'b0; m_err <= 1'b0; m_busy <= 1'b0;
        m_data <= '0; m_rzero <= 1'b1; m_quiet <= 1'b1;
      end else if (flush) begin
        m_valid <= 1'b0; m_err <= 1'b0; m_busy <= 1'b0; m_quiet <= 1'b1;
      end else if (m_valid) begin
        if (bus.S_RREADY) begin
          m_valid <= 1'b0; m_err <= 1'b0;
        end
      end else if (m_busy) begin
        if (cyc == due) begin
          m_busy <= 1'b0; m_valid <= 1'b1; m_err <= 1'b0;
          m_data <= word_data(m_word); m_rzero <= 1'b0; m_quiet <= 1'b0;
        end
      end else if (bus.S_ARVALID) begin
        if (addr_ok(bus.S_ARADDR)) begin
          m_busy <= 1'b1; due <= cyc + LAT; m_word <= bus.S_ARADDR >> 2;
        end else begin
          m_valid <= 1'b1; m_err <= 1'b1; m_data <= 32'h0000_0000;
          m_rzero <= 1'b0; m_quiet <= 1'b0;
        end
      end
      cyc <= cyc + 1;
    end

    always @(negedge clk) begin
      logic exp_en;
      if (cyc > 0) begin
        exp_en = rst_n && !m_valid && !m_busy && bus.S_ARVALID && addr_ok(bus.S_ARADDR);
        check($sformatf("L%0d bram_en", LAT), 32'(bram_en), 32'(exp_en));
        if (exp_en)
          check($sformatf("L%0d bram_addr", LAT), 32'(bram_addr), bus.S_ARADDR >> 2);
        check($sformatf("L%0d rvalid", LAT), 32'(bus.S_RVALID), 32'(m_valid));
        if (m_valid || m_quiet)
          check($sformatf("L%0d rerr", LAT), 32'(bus.S_RERR), 32'(m_err));
        if (m_valid || m_rzero)
          check($sformatf("L%0d rdata", LAT), bus.S_RDATA, m_data);
      end
    end

    initial begin
      req_t q[$];
      req_t r;
      int   k, held;
      bit   fin;
      q.push_back('{32'h0000_0010, 5, NONE, NONE, 0});
      q.push_back('{32'h0000_0014, 0, NONE, NONE, 1});
      q.push_back('{32'h0000_0012, 1, NONE, NONE, 0});
      q.push_back('{32'h0000_4000, 0, NONE, NONE, 0});
      q.push_back('{32'h0000_3FFC, 0, NONE, NONE, 0});
      q.push_back('{32'h0000_0010, 0, 1, NONE, 0});
      q.push_back('{32'h0000_0020, 0, NONE, NONE, 0});
      q.push_back('{32'h0000_0030, 0, NONE, 1, 0});
      q.push_back('{32'h0000_0040, 2, NONE, NONE, 0});
      for (int i = 0; i < 60; i++) q.push_back(rand_req(LAT));

      bus.S_ARADDR  = '0;
      bus.S_ARVALID = 1'b0;
      bus.S_RREADY  = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      foreach (q[i]) begin
        r = q[i];
        bus.S_ARADDR  = r.addr;
        bus.S_ARVALID = 1'b1;
        k = 0; held = 0; fin = 1'b0;
        while (!fin) begin
          bus.S_RREADY = 1'b0;
          if (k == r.flush_at) begin
            flush = 1'b1;
            bus.S_RREADY = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            flush = 1'b0;
            fin = 1'b1;
          end else if (k == r.reset_at) begin
            rst_n = 1'b0;
            @(posedge clk); #1;
            rst_n = 1'b1;
            fin = 1'b1;
          end else if (bus.S_RVALID === 1'b1) begin
            if (held == r.hold) begin
              bus.S_RREADY = 1'b1;
              @(posedge clk); #1;
              bus.S_RREADY = 1'b0;
              fin = 1'b1;
            end else begin
              held++;
              @(posedge clk); #1;
            end
          end else if (k > 40) begin
            check($sformatf("L%0d response timeout", LAT), 32'(bus.S_RVALID), 32'd1);
            fin = 1'b1;
          end else begin
            bus.S_RREADY = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
          end
          k++;
        end
        if (r.gap > 0) begin
          bus.S_ARVALID = 1'b0;
          bus.S_ARADDR  = $urandom;
          repeat (r.gap) begin
            bus.S_RREADY = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
          end
          bus.S_RREADY = 1'b0;
        end
      end
      bus.S_ARVALID = 1'b0;
      repeat (LAT + 4) @(posedge clk);
      done = 1'b1;
    end
  end

  initial begin
    int unsigned t = 0;
    while (!(lane[0].done && lane[1].done && lane[2].done) && t < 40000) begin
      @(posedge clk);
      t++;
    end
    if (!(lane[0].done && lane[1].done && lane[2].done))
      check("lanes finished", {29'b0, lane[2].done, lane[1].done, lane[0].done}, 32'h7);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/imem_read_port.md
Name: imem_read_port

Overview:
- Instruction-side memory port directly upstream of the fetch stage.
- Accepts fetch read requests (ARADDR/ARVALID) and drives a fixed-latency synchronous instruction BRAM.
- Returns one 32-bit instruction word with RVALID and holds it until the fetch stage consumes it.
- Flags misaligned and out-of-range addresses without accessing the BRAM.

Parameters:
ADDR_WIDTH, 12, BRAM word-address width (memory size = 2^ADDR_WIDTH words)
READ_LATENCY, 2, BRAM read latency in cycles from BRAM_EN to BRAM_DOUT valid; legal range 1..4
NOP_WORD, 32'h0000_0000, data returned on error responses

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
FLUSH  in  1  abort in-flight or held response
S_ARADDR  in  32  byte address from fetch; stable while a request is outstanding
S_ARVALID  in  1  fetch request valid
S_RREADY  in  1  fetch consumes held word this cycle (fetch's valid&&ready)
S_RDATA  out  32  instruction word
S_RVALID  out  1  S_RDATA valid for the current S_ARADDR
S_RERR  out  1  response is an error (misaligned or out of range); qualified by S_RVALID
BRAM_EN  out  1  BRAM read enable
BRAM_ADDR  out  ADDR_WIDTH  BRAM word address
BRAM_DOUT  in  32  BRAM read data

Behaviour:
- Reset (rst_n=0 at posedge): state IDLE, S_RVALID=0, S_RDATA=0, S_RERR=0, counter=0. BRAM_EN=0 while in reset. Reset mid-read abandons the read; later BRAM_DOUT is ignored.
- FSM states: IDLE, WAIT, HOLD.
- IDLE, S_ARVALID=1, address legal (S_ARADDR[1:0]==0 and S_ARADDR[31:ADDR_WIDTH+2]==0):
  - BRAM_EN=1 combinationally this cycle; BRAM_ADDR=S_ARADDR[ADDR_WIDTH+1:2].
  - Load counter=READ_LATENCY; go to WAIT.
- IDLE, S_ARVALID=1, address illegal:
  - No BRAM access.
  - Next cycle: HOLD, S_RDATA=NOP_WORD, S_RERR=1, S_RVALID=1.
- IDLE, S_ARVALID=0: stay; BRAM_EN=0.
- WAIT:
  - Counter decrements each cycle.
  - In the cycle it reaches 0, BRAM_DOUT is valid (issue cycle T, data at T+READ_LATENCY). Capture it into S_RDATA with S_RERR=0; S_RVALID=1 from cycle T+READ_LATENCY+1; go to HOLD.
  - BRAM_EN=0 throughout WAIT.
- HOLD:
  - S_RDATA/S_RVALID/S_RERR held stable.
  - S_RREADY=1: next cycle IDLE, S_RVALID=0. The new address is sampled in that IDLE cycle.
  - Back-to-back fetch cost: READ_LATENCY+2 cycles per legal word.
- FLUSH (any state): next cycle IDLE, S_RVALID=0, S_RERR=0. In-flight BRAM data is discarded. FLUSH has priority over S_RREADY and over counter expiry.
- Stale data: stale BRAM outputs from a flushed read arrive before a reissued read's expiry and are never captured (fixed-latency pipeline).
- S_ARADDR changes during WAIT/HOLD are protocol violations; the latched request is served regardless.
- Counter width: $clog2(READ_LATENCY+1) bits; never wraps below 0.
- S_RREADY while S_RVALID=0: ignored.

Decomposition:
- Shared package/config include: state encodings (IMEM_IDLE, IMEM_WAIT, IMEM_HOLD), NOP_WORD default, error-code bit position.
- Single module. An optional sub-module, imem_latency_counter (load/decrement/zero flag), is natural; inline is acceptable.

Test Plan:
- Legal read, READ_LATENCY=2, ARADDR=0x0000_0010, BRAM word 4=0xDEAD_BEEF; request in cycle 0 -> BRAM_EN=1 with BRAM_ADDR=4 in cycle 0; S_RVALID=1, S_RDATA=0xDEAD_BEEF, S_RERR=0 from cycle 3; held while S_RREADY=0 for 5 cycles.
- Consume and next fetch: S_RREADY=1 in HOLD, then ARADDR=0x14 -> S_RVALID=0 next cycle, BRAM_ADDR=5 issued that cycle, word 5 returned 3 cycles later.
- Misaligned ARADDR=0x0000_0012 -> no BRAM_EN; next cycle S_RVALID=1, S_RERR=1, S_RDATA=0x0000_0000.
- Out of range, ADDR_WIDTH=12, ARADDR=0x0000_4000 -> S_RERR=1, no BRAM access.
- FLUSH one cycle after issue of 0x10, then reissue 0x20 -> only word 8 returned; word 4 never appears on S_RDATA.
- rst_n=0 during WAIT -> all outputs 0 next cycle; after release, a fresh request completes normally. Repeat the legal-read scenario for READ_LATENCY=1 and 4: S_RVALID at cycle L+1.
